aes_axis_block_receiver: RTL and testbench

//  Sink end of the AES core's 128-bit output AXI-Stream (connects to aes256_ctr_mode m_axis_*).

---
 rtl/aes_axis_block_receiver.sv | 186 ++++++++++++++++++
 tb/tb_aes_axis_block_receiver.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_block_receiver.sv
// aes_axis_block_receiver
//   Sink for the AES core's 128-bit AXI-Stream output. Blocks ({tlast, tdata})
//   are buffered in a DEPTH-entry FIFO and serialised MS word first into a
//   32-bit read port. Accepted blocks and frames are counted, and the FIFO
//   fill state is reported in status_register.
//
//   Optional feature macro: AXIS_RX_PROTOCOL_CHECK_EN
//     defined   : sticky proto_err (status bit 2) flags a stalled transfer
//                 whose tvalid drops or whose tdata/tlast change before the
//                 handshake completes.
//     undefined : checker absent, status bit 2 reads 0.
//
//   Handshake semantics: a block transfers on a rising edge where
//   s_axis_tvalid && s_axis_tready (and clear is low). s_axis_tready is a
//   register derived from the FIFO level only, so there is no combinational
//   path from tvalid or rd_en to tready. On the read side a word is consumed
//   on a rising edge where rd_valid && rd_en; rd_en is ignored while
//   rd_valid is low.
module aes_axis_block_receiver #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [127:0]         s_axis_tdata,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 rd_last,
  output logic [CNT_WIDTH-1:0] blk_count,
  output logic [31:0]          status_register
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  // FIFO storage and control
  logic [128:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_next;
  logic           tready_q;
  logic           fifo_empty;
  logic           fifo_full;

  // Serialiser: current word always sits in ser_data[127:96]
  logic [127:0]   ser_data;
  logic           ser_last;
  logic [1:0]     ser_idx;
  logic           ser_valid;

  // Counters and checker flag
  logic [CNT_WIDTH-1:0] blk_cnt;
  logic [15:0]          frame_cnt;
  logic                 proto_err;

  // Per-cycle events
  logic push;
  logic rd_pop;
  logic load;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));

  // Event decode: clear and rst suppress every state-changing event
  always_comb begin
    push   = s_axis_tvalid && tready_q && !clear && !rst;
    rd_pop = rd_en && ser_valid && !clear && !rst;
    load   = !fifo_empty && !clear && !rst &&
             (!ser_valid || (rd_pop && (ser_idx == 2'd3)));
  end

  // Next FIFO level: a push and a load on the same edge cancel out
  always_comb begin
    level_next = level;
    if (push && !load) begin
      level_next = level + LW'(1);
    end else if (!push && load) begin
      level_next = level - LW'(1);
    end
  end

  // FIFO data array (no reset needed, contents qualified by level)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // FIFO pointers, level and the registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tready_q <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level    <= level_next;
      tready_q <= (level_next != LW'(DEPTH));
    end
  end

  // Serialiser: load a fresh block when idle or as word 3 leaves, else shift
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ser_data  <= '0;
      ser_last  <= 1'b0;
      ser_idx   <= 2'd0;
      ser_valid <= 1'b0;
    end else if (load) begin
      ser_data  <= mem[rd_ptr][127:0];
      ser_last  <= mem[rd_ptr][128];
      ser_idx   <= 2'd0;
      ser_valid <= 1'b1;
    end else if (rd_pop) begin
      ser_data <= {ser_data[95:0], 32'h0};
      ser_idx  <= ser_idx + 2'd1;
      if (ser_idx == 2'd3) begin
        ser_valid <= 1'b0;
      end
    end
  end

  // Block and frame counters, both wrap naturally
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      blk_cnt   <= '0;
      frame_cnt <= '0;
    end else if (push) begin
      blk_cnt <= blk_cnt + CNT_WIDTH'(1);
      if (s_axis_tlast) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef AXIS_RX_PROTOCOL_CHECK_EN
  logic         stall_q;
  logic [127:0] held_data;
  logic         held_last;

  // Protocol checker: a stalled beat must be held unchanged until accepted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stall_q   <= 1'b0;
      held_data <= '0;
      held_last <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (stall_q && (!s_axis_tvalid || (s_axis_tdata != held_data) ||
                      (s_axis_tlast != held_last))) begin
        proto_err <= 1'b1;
      end
      stall_q   <= s_axis_tvalid && !tready_q;
      held_data <= s_axis_tdata;
      held_last <= s_axis_tlast;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

  assign s_axis_tready   = tready_q;
  assign rd_valid        = ser_valid;
  assign rd_data         = ser_data[127:96];
  assign rd_last         = ser_valid && ser_last && (ser_idx == 2'd3);
  assign blk_count       = blk_cnt;
  assign status_register = {frame_cnt, 8'(level), 5'b0, proto_err, fifo_full, fifo_empty};

endmodule

// File: tb/tb_aes_axis_block_receiver.sv
// tb_aes_axis_block_receiver
//   Directed scenarios (reset, NIST CTR blocks, fill, simultaneous push/pop,
//   clear, optional protocol checker) followed by randomized traffic. A
//   queue-based model of the receiver is compared against the DUT every
//   cycle.
`timescale 1ns/1ps
module tb_aes_axis_block_receiver;

  localparam int DEPTH = 16;
  localparam int W     = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [127:0] s_axis_tdata = '0;
  logic         rd_en = 1'b0;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic [31:0]  blk_count;
  logic [31:0]  status_register;

  always #5 clk = ~clk;

  aes_axis_block_receiver #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdata    (s_axis_tdata),
    .rd_en           (rd_en),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_last         (rd_last),
    .blk_count       (blk_count),
    .status_register (status_register)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // blk_q holds buffered blocks; exp_q/exp_last_q hold the words of the
  // block currently being presented on the read port.
  logic [128:0]  blk_q[$];
  logic [W-1:0]  exp_q[$];
  logic          exp_last_q[$];
  logic          m_tready = 1'b0;
  logic [31:0]   m_blk = '0;
  logic [15:0]   m_frame = '0;
  logic          m_perr = 1'b0;
  logic          m_stall = 1'b0;
  logic [127:0]  m_pdata = '0;
  logic          m_plast = 1'b0;
  logic          model_ok = 1'b0;
  logic [128:0]  m_b;
  logic          m_acc;

  function automatic logic [31:0] m_status();
    return {m_frame, 8'(blk_q.size()), 5'b0, m_perr,
            logic'(blk_q.size() == DEPTH), logic'(blk_q.size() == 0)};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_ok = 1'b1;
      if (rst || clear) begin
        blk_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        m_blk = '0;
        m_frame = '0;
        m_perr = 1'b0;
        m_stall = 1'b0;
        m_tready = !rst;
      end else begin
        m_acc = s_axis_tvalid && m_tready;
`ifdef AXIS_RX_PROTOCOL_CHECK_EN
        if (m_stall && (!s_axis_tvalid || s_axis_tdata != m_pdata || s_axis_tlast != m_plast))
          m_perr = 1'b1;
        m_stall = s_axis_tvalid && !m_tready;
        m_pdata = s_axis_tdata;
        m_plast = s_axis_tlast;
`endif
        if (rd_en && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
        if (exp_q.size() == 0 && blk_q.size() > 0) begin
          m_b = blk_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            exp_q.push_back(m_b[127-32*k -: 32]);
            exp_last_q.push_back((k == 3) && m_b[128]);
          end
        end
        if (m_acc) begin
          blk_q.push_back({s_axis_tlast, s_axis_tdata});
          m_blk = m_blk + 32'd1;
          if (s_axis_tlast) m_frame = m_frame + 16'd1;
        end
        m_tready = (blk_q.size() != DEPTH);
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("tready", s_axis_tready, m_tready);
        check("rd_valid", rd_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          check("rd_data", rd_data, exp_q[0]);
          check("rd_last", rd_last, exp_last_q[0]);
        end
        check("blk_count", blk_count, m_blk);
        check("status", status_register, m_status());
      end
    end
  end

  // Capture of consumed words for the literal NIST check
  logic [31:0] cap_q[$];
  logic        cap_last_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid && rd_en && !clear && !rst) begin
        cap_q.push_back(rd_data);
        cap_last_q.push_back(rd_last);
      end
    end
  end

  // Watchdog
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc > 60000) begin
        n_err++;
        $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_block(input logic [127:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = s_axis_tready;
      tick();
    end
    s_axis_tvalid = 1'b0;
    check("push_accepted", ok, 1'b1);
  endtask

  // Keep tvalid high for a number of cycles; new data only after a handshake
  task automatic stream(input int cycles, output int n_acc);
    bit hs;
    n_acc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand128();
    s_axis_tlast  = 1'($urandom_range(0, 1));
    for (int i = 0; i < cycles; i++) begin
      hs = s_axis_tready;
      tick();
      if (hs) begin
        n_acc++;
        s_axis_tdata = rand128();
        s_axis_tlast = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Hold a pending beat until it is accepted, then drop tvalid
  task automatic finish_stream();
    for (int i = 0; i < 200 && s_axis_tvalid; i++) begin
      if (s_axis_tready) begin
        tick();
        s_axis_tvalid = 1'b0;
      end else begin
        tick();
      end
    end
    check("stream_done", s_axis_tvalid, 1'b0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      done = status_register[0] && !rd_valid && !s_axis_tvalid;
      if (!done) tick();
    end
    check("drained", done, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] nist_blk [4];
  logic [31:0]  nist_w   [16];
  int           n_acc;
  bit           last_hs;
  int           rd_pct;

  initial begin
    nist_blk[0] = 128'h601EC313775789A5B7A7F504BBF3D228;
    nist_blk[1] = 128'hF443E3CA4D62B59ACA84E990CACAF5C5;
    nist_blk[2] = 128'h2B0930DAA23DE94CE87017BA2D84988D;
    nist_blk[3] = 128'hDFC9C58DB67AADA613C2DD08457941A6;
    nist_w = '{32'h601EC313, 32'h775789A5, 32'hB7A7F504, 32'hBBF3D228,
               32'hF443E3CA, 32'h4D62B59A, 32'hCA84E990, 32'hCACAF5C5,
               32'h2B0930DA, 32'hA23DE94C, 32'hE87017BA, 32'h2D84988D,
               32'hDFC9C58D, 32'hB67AADA6, 32'h13C2DD08, 32'h457941A6};

    // 1: reset held for 3 cycles
    repeat (3) tick();
    check("rst_status", status_register, 32'h0000_0001);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_blk_count", blk_count, 32'h0);
    check("rst_tready", s_axis_tready, 1'b0);
    rst = 1'b0;
    tick();
    check("tready_after_rst", s_axis_tready, 1'b1);

    // 2: NIST CTR output blocks with continuous reading
    cap_q.delete();
    cap_last_q.delete();
    rd_en = 1'b1;
    for (int b = 0; b < 4; b++) push_block(nist_blk[b], b == 3);
    for (int i = 0; i < 40 && cap_q.size() < 16; i++) tick();
    check("nist_word_count", cap_q.size(), 16);
    if (cap_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("nist_word%0d", i), cap_q[i], nist_w[i]);
        check($sformatf("nist_last%0d", i), cap_last_q[i], i == 15);
      end
    end
    check("nist_blk_count", blk_count, 32'd4);
    check("nist_frame_count", status_register[31:16], 16'd1);
    rd_en = 1'b0;
    wait_drain();

    // 3: fill with no reads: 16 in the FIFO plus 1 in the serialiser
    stream(20, n_acc);
    check("fill_accepted", n_acc, 17);
    check("fill_full_bit", status_register[1], 1'b1);
    check("fill_level", status_register[15:8], 8'd16);
    check("fill_tready", s_axis_tready, 1'b0);
    rd_en = 1'b1;
    finish_stream();
    wait_drain();
    rd_en = 1'b0;

    // 4: full FIFO, pop word 3 while a beat is stalled
    stream(20, n_acc);
    check("full2_accepted", n_acc, 17);
    rd_en = 1'b1;
    repeat (4) tick();
    check("pop3_level", status_register[15:8], 8'd15);
    check("pop3_tready", s_axis_tready, 1'b1);
    rd_en = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
    check("refill_level", status_register[15:8], 8'd16);
    check("refill_tready", s_axis_tready, 1'b0);
    rd_en = 1'b1;
    wait_drain();
    rd_en = 1'b0;

    // 5: clear with two blocks buffered and a beat offered
    push_block(rand128(), 1'b0);
    push_block(rand128(), 1'b1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand128();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    s_axis_tvalid = 1'b0;
    check("clr_status", status_register, 32'h0000_0001);
    check("clr_blk_count", blk_count, 32'h0);
    check("clr_rd_valid", rd_valid, 1'b0);
    check("clr_rd_data", rd_data, 32'h0);
    check("clr_tready", s_axis_tready, 1'b1);
    repeat (3) tick();
    check("clr_beat_dropped", rd_valid, 1'b0);

    // 6: stalled beat modified before acceptance
    stream(20, n_acc);
`ifdef AXIS_RX_PROTOCOL_CHECK_EN
    check("perr_before", status_register[2], 1'b0);
    s_axis_tdata = ~s_axis_tdata;
    tick();
    check("perr_set", status_register[2], 1'b1);
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("perr_sticky", status_register[2], 1'b1);
`endif
    s_axis_tvalid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("perr_cleared", status_register[2], 1'b0);
    check("clr2_status", status_register, 32'h0000_0001);

    // Randomized traffic in three read-pressure phases
    last_hs = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      rd_pct = (ph == 0) ? 30 : (ph == 1) ? 75 : 100;
      for (int c = 0; c < 1500; c++) begin
        if (!s_axis_tvalid || last_hs) begin
          s_axis_tvalid = ($urandom_range(0, 3) != 0);
          s_axis_tdata  = rand128();
          s_axis_tlast  = ($urandom_range(0, 3) == 0);
        end
        clear   = ($urandom_range(0, 199) == 0);
        rd_en   = ($urandom_range(0, 99) < rd_pct);
        last_hs = s_axis_tvalid && s_axis_tready && !clear;
        tick();
      end
    end
    s_axis_tvalid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rd_en = 1'b0;
    repeat (2) tick();
    check("end_status", status_register, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
